// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux: valid/ready on every input, one registered output stage.
// Fixed-priority (ARB_MODE=0) or round-robin (ARB_MODE=1) selection, one transfer per cycle.
module rr_arb_mux #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ARB_MODE = 1,
  parameter int unsigned CH_W     = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NUM_CH-1:0]       req_valid_i,
  input  logic [NUM_CH*WIDTH-1:0] req_data_i,
  output logic [NUM_CH-1:0]       req_ready_o,
  output logic                    out_valid_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [CH_W-1:0]         out_ch_o,
  input  logic                    out_ready_i
);

  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;

  logic             load;
  logic             xfer;
  logic             gnt_found;
  logic [CH_W-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // base + off modulo NUM_CH; both operands are already below NUM_CH
  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return CH_W'(sum);
  endfunction

  assign load = ~out_valid_q | out_ready_i;
  assign xfer = load & gnt_found;

  // First valid channel at or above the pointer, wrapping at NUM_CH-1
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!gnt_found && req_valid_i[wrap_idx(ptr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(ptr_q, i);
      end
    end
  end

  // Only the granted lane reaches the data path, so idle lanes never leak through
  always_comb begin
    gnt_data    = '0;
    req_ready_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == CH_W'(k)) begin
        gnt_data       = req_data_i[k*WIDTH +: WIDTH];
        req_ready_o[k] = load & gnt_found;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (ARB_MODE != 0 && xfer) begin
      ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
    if (load) begin
      out_valid_d = gnt_found;
      if (gnt_found) begin
        out_data_d = gnt_data;
        out_ch_d   = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

endmodule
